shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine_pkg.sv | 14 +
 rtl/shift_lane.sv | 62 ++++++
 rtl/shift_engine.sv | 121 ++++++++++++
 tb/tb_shift_engine.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared definitions for the shift engine: shift-direction constants and the
// helper that sizes the per-word bit counter.
package shift_engine_pkg;

  // Shift-direction encodings for the MSB_FIRST parameter.
  localparam bit DIR_LSB_FIRST = 1'b0;
  localparam bit DIR_MSB_FIRST = 1'b1;

  // Counter width able to hold values 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : shift_engine_pkg

// File: rtl/shift_lane.sv
// One lane of the shift engine: the active shift register and its carry flop.
// Control (when to shift, when to load) comes from the shared controller.
module shift_lane
  import shift_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = DIR_MSB_FIRST
) (
  input  logic             Clock,
  input  logic             Preset,
  input  logic             load_en,    // replace active word with load_data
  input  logic             shift_en,   // shift one bit this edge
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  logic [WIDTH-1:0] active_d, active_q;
  logic             carry_d, carry_q;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;

  // Next-state selection: shift, shift-and-reload (last bit of a word), or plain load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    active_d = active_q;
    carry_d  = carry_q;
    if (MSB_FIRST) begin
      shifted = {active_q[WIDTH-2:0], ser_in};
      out_bit = active_q[WIDTH-1];
    end else begin
      shifted = {ser_in, active_q[WIDTH-1:1]};
      out_bit = active_q[0];
    end
    if (shift_en) begin
      // On the final shift of a word a pending word replaces the shifted value,
      // but the carry still reports the bit that just left.
      carry_d  = out_bit;
      active_d = load_en ? load_data : shifted;
    end else if (load_en) begin
      active_d = load_data;
      carry_d  = 1'b0;
    end
  end

  // Lane state register with asynchronous active-high reset.
  always_ff @(posedge Clock or posedge Preset) begin
    if (Preset) begin
      active_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      active_q <= active_d;
      carry_q  <= carry_d;
    end
  end

  assign q     = active_q;
  assign carry = carry_q;

endmodule : shift_lane

// File: rtl/shift_engine.sv
// Multi-lane parallel-load / serial-shift engine with a one-word holding
// register so consecutive words stream with no gap between them.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 1,
  parameter bit MSB_FIRST = DIR_MSB_FIRST
) (
  input  logic                      Clock,
  input  logic                      Preset,
  input  logic [CHANNELS*WIDTH-1:0] Dp,
  input  logic                      LoadValid,
  output logic                      LoadReady,
  input  logic [CHANNELS-1:0]       Ds,
  input  logic                      ShiftEn,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       Carry,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Underrun
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [CHANNELS*WIDTH-1:0] hold_d, hold_q;
  logic                      hold_full_d, hold_full_q;
  logic                      busy_d, busy_q;
  logic [CW-1:0]             count_d, count_q;
  logic                      done_d, done_q;
  logic                      underrun_d, underrun_q;

  logic accept;      // holding register captures Dp this edge
  logic do_shift;    // active word shifts this edge
  logic last_shift;  // this shift empties the active word
  logic idle_xfer;   // idle engine pulls the held word into the lanes
  logic lane_load;   // lanes take the held word this edge

  // Handshake and transfer decode shared by the controller and the lanes.
  always_comb begin
    accept     = LoadValid && !hold_full_q;
    do_shift   = busy_q && ShiftEn;
    last_shift = do_shift && (count_q == LAST_COUNT);
    idle_xfer  = !busy_q && hold_full_q;
    lane_load  = idle_xfer || (last_shift && hold_full_q);
  end

  // Controller next state: holding register, bit counter, busy and pulse flags.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    busy_d      = busy_q;
    count_d     = count_q;
    done_d      = last_shift;
    underrun_d  = last_shift && !hold_full_q;

    // accept needs an empty holder and lane_load needs a full one, so the two
    // never coincide.
    if (accept) begin
      hold_d      = Dp;
      hold_full_d = 1'b1;
    end else if (lane_load) begin
      hold_full_d = 1'b0;
    end

    if (idle_xfer) begin
      busy_d  = 1'b1;
      count_d = '0;
    end else if (last_shift) begin
      busy_d  = hold_full_q;
      count_d = '0;
    end else if (do_shift) begin
      count_d = count_q + CW'(1);
    end
  end

  // Controller state register; the holding register is cleared on reset too
  // so a stale word can never be transferred after Preset.
  always_ff @(posedge Clock or posedge Preset) begin
    if (Preset) begin
      // NOTE: the holding register is a datapath word but is reset anyway; Preset must discard it.
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  // One lane per channel, all driven by the shared shift/load strobes.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    shift_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .Clock     (Clock),
      .Preset    (Preset),
      .load_en   (lane_load),
      .shift_en  (do_shift),
      .load_data (hold_q[n*WIDTH +: WIDTH]),
      .ser_in    (Ds[n]),
      .q         (Q[n*WIDTH +: WIDTH]),
      .carry     (Carry[n])
    );
  end

  assign LoadReady = !hold_full_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Underrun  = underrun_q;

endmodule : shift_engine

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=8, CHANNELS=2). Two instances
// share all inputs: one shifts MSB-first, the other LSB-first.
module tb_shift_engine;

  localparam int W  = 8;
  localparam int CH = 2;

  logic              Clock;
  logic              Preset;
  logic [CH*W-1:0]   Dp;
  logic              LoadValid;
  logic [CH-1:0]     Ds;
  logic              ShiftEn;

  logic [CH*W-1:0]   Q_m, Q_l;
  logic [CH-1:0]     Carry_m, Carry_l;
  logic              LoadReady_m, LoadReady_l;
  logic              Busy_m, Busy_l, Done_m, Done_l, Underrun_m, Underrun_l;

  int n_checks = 0;
  int n_fail   = 0;

  shift_engine #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b1)) dut_m (
    .Clock(Clock), .Preset(Preset), .Dp(Dp), .LoadValid(LoadValid),
    .LoadReady(LoadReady_m), .Ds(Ds), .ShiftEn(ShiftEn), .Q(Q_m),
    .Carry(Carry_m), .Busy(Busy_m), .Done(Done_m), .Underrun(Underrun_m)
  );

  shift_engine #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b0)) dut_l (
    .Clock(Clock), .Preset(Preset), .Dp(Dp), .LoadValid(LoadValid),
    .LoadReady(LoadReady_l), .Ds(Ds), .ShiftEn(ShiftEn), .Q(Q_l),
    .Carry(Carry_l), .Busy(Busy_l), .Done(Done_l), .Underrun(Underrun_l)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- behavioural reference model ----------------
  // Word-level view: a pending word, the word being shifted out and the
  // number of bits still left in it.
  typedef struct {
    logic [CH*W-1:0] act;
    logic [CH-1:0]   carry;
    logic [CH*W-1:0] hold;
    bit              hold_full;
    bit              busy;
    int              left;
    bit              done;
    bit              under;
  } model_t;

  model_t mm, ml;

  function automatic model_t model_reset();
    model_t r;
    r.act = '0; r.carry = '0; r.hold = '0; r.hold_full = 0;
    r.busy = 0; r.left = 0; r.done = 0; r.under = 0;
    return r;
  endfunction

  function automatic model_t model_step(model_t m, bit msb, logic lv,
                                        logic [CH*W-1:0] dp, logic [CH-1:0] ds,
                                        logic se);
    model_t n;
    logic [W-1:0] w;
    bit take;
    n = m;
    n.done  = 0;
    n.under = 0;
    take = lv && !m.hold_full;
    if (m.busy && se) begin
      for (int l = 0; l < CH; l++) begin
        w = m.act[l*W +: W];
        if (msb) begin
          n.carry[l] = w[W-1];
          w = (w << 1) | W'(ds[l]);
        end else begin
          n.carry[l] = w[0];
          w = (w >> 1) | (W'(ds[l]) << (W-1));
        end
        n.act[l*W +: W] = w;
      end
      n.left = m.left - 1;
      if (n.left == 0) begin
        n.done = 1;
        if (m.hold_full) begin
          n.act = m.hold; n.left = W; n.hold_full = 0;
        end else begin
          n.busy = 0; n.under = 1;
        end
      end
    end else if (!m.busy && m.hold_full) begin
      n.act = m.hold; n.left = W; n.busy = 1; n.carry = '0; n.hold_full = 0;
    end
    if (take) begin
      n.hold = dp; n.hold_full = 1;
    end
    return n;
  endfunction

  always @(posedge Clock or posedge Preset) begin
    if (Preset) begin
      mm <= model_reset();
      ml <= model_reset();
    end else begin
      mm <= model_step(mm, 1'b1, LoadValid, Dp, Ds, ShiftEn);
      ml <= model_step(ml, 1'b0, LoadValid, Dp, Ds, ShiftEn);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Preset = 1'b1; LoadValid = 1'b0; ShiftEn = 1'b0; Ds = '0; Dp = '0;
    @(negedge Clock);
    @(negedge Clock);
    Preset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [21:0] exp_o;
    do_reset();
    exp_o = {16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    n_checks++;
    if ({Q_m, Carry_m, Busy_m, Done_m, Underrun_m, LoadReady_m} !== exp_o) begin
      n_fail++;
      $display("FAIL reset_msb: got %h expected %h",
               {Q_m, Carry_m, Busy_m, Done_m, Underrun_m, LoadReady_m}, exp_o);
    end
    n_checks++;
    if ({Q_l, Carry_l, Busy_l, Done_l, Underrun_l, LoadReady_l} !== exp_o) begin
      n_fail++;
      $display("FAIL reset_lsb: got %h expected %h",
               {Q_l, Carry_l, Busy_l, Done_l, Underrun_l, LoadReady_l}, exp_o);
    end
  endtask

  task automatic test_carry_order();
    logic [7:0] seq0, seq1;
    logic [1:0] exp_cm, exp_cl;
    seq0 = 8'h3C;
    seq1 = 8'hA5;
    do_reset();
    LoadValid = 1'b1; Dp = 16'hA53C; Ds = 2'b00; ShiftEn = 1'b1;
    tick();
    LoadValid = 1'b0;
    n_checks++;
    if (Busy_m !== 1'b0 || Busy_l !== 1'b0 || LoadReady_m !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_one_edge_after_accept: busy %b/%b ready %b expected 0/0 0",
               Busy_m, Busy_l, LoadReady_m);
    end
    tick();
    n_checks++;
    if (Busy_m !== 1'b1 || Busy_l !== 1'b1 || Carry_m !== 2'b00 || Q_m !== 16'hA53C) begin
      n_fail++;
      $display("FAIL busy_two_edges_after_accept: busy %b/%b carry %b q %h expected 1/1 00 a53c",
               Busy_m, Busy_l, Carry_m, Q_m);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_cm = {seq1[7-i], seq0[7-i]};
      exp_cl = {seq1[i], seq0[i]};
      n_checks++;
      if (Carry_m !== exp_cm) begin
        n_fail++;
        $display("FAIL carry_msb_first[%0d]: got %b expected %b", i, Carry_m, exp_cm);
      end
      n_checks++;
      if (Carry_l !== exp_cl) begin
        n_fail++;
        $display("FAIL carry_lsb_first[%0d]: got %b expected %b", i, Carry_l, exp_cl);
      end
      n_checks++;
      if ({Done_m, Underrun_m, Busy_m, Done_l, Underrun_l, Busy_l} !==
          ((i == 7) ? 6'b110_110 : 6'b001_001)) begin
        n_fail++;
        $display("FAIL flags_shift[%0d]: got %b expected %b", i,
                 {Done_m, Underrun_m, Busy_m, Done_l, Underrun_l, Busy_l},
                 (i == 7) ? 6'b110_110 : 6'b001_001);
      end
    end
    n_checks++;
    if (Q_m !== 16'h0000 || Q_l !== 16'h0000) begin
      n_fail++;
      $display("FAIL final_q: got %h/%h expected 0000/0000", Q_m, Q_l);
    end
    tick();
    n_checks++;
    if ({Done_m, Underrun_m, Done_l, Underrun_l} !== 4'b0000) begin
      n_fail++;
      $display("FAIL pulse_width: got %b expected 0000", {Done_m, Underrun_m, Done_l, Underrun_l});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_f;
    do_reset();
    LoadValid = 1'b1; Dp = 16'hFF00; Ds = 2'b00; ShiftEn = 1'b1;
    tick();                 // accept first word
    Dp = 16'h00FF;
    tick();                 // idle transfer; holder empties
    n_checks++;
    if (LoadReady_m !== 1'b1 || Busy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_after_transfer: ready %b busy %b expected 1 1", LoadReady_m, Busy_m);
    end
    tick();                 // accept second word together with shift 1
    LoadValid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) tick();
      exp_f = {(k != 16), (k == 8 || k == 16), (k == 16)};
      n_checks++;
      if ({Busy_m, Done_m, Underrun_m} !== exp_f || {Busy_l, Done_l, Underrun_l} !== exp_f) begin
        n_fail++;
        $display("FAIL b2b_flags[%0d]: got %b/%b expected %b", k,
                 {Busy_m, Done_m, Underrun_m}, {Busy_l, Done_l, Underrun_l}, exp_f);
      end
      if (k == 8) begin
        n_checks++;
        if (Q_m !== 16'h00FF || Q_l !== 16'h00FF) begin
          n_fail++;
          $display("FAIL b2b_reload_q: got %h/%h expected 00ff", Q_m, Q_l);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int edges;
    bit seen_done;
    logic [CH*W-1:0] qm_prev, ql_prev;
    logic [CH-1:0]   cm_prev;
    do_reset();
    LoadValid = 1'b1; Dp = 16'($urandom); ShiftEn = 1'b0;
    tick();
    LoadValid = 1'b0;
    tick();
    edges = 0;
    seen_done = 0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      ShiftEn = (c % 2 == 1);
      Ds = 2'($urandom);
      qm_prev = Q_m; ql_prev = Q_l; cm_prev = Carry_m;
      tick();
      edges++;
      if (!ShiftEn) begin
        n_checks++;
        if (Q_m !== qm_prev || Q_l !== ql_prev || Carry_m !== cm_prev) begin
          n_fail++;
          $display("FAIL toggle_hold[%0d]: q %h/%h expected %h/%h", c, Q_m, Q_l, qm_prev, ql_prev);
        end
      end
      if (Done_m === 1'b1) seen_done = 1;
    end
    n_checks++;
    if (!seen_done || edges != 16) begin
      n_fail++;
      $display("FAIL toggle_cycles: done seen %0d after %0d edges expected 1 after 16", seen_done, edges);
    end
    ShiftEn = 1'b1;
    qm_prev = Q_m; ql_prev = Q_l; cm_prev = Carry_m;
    for (int c = 0; c < 3; c++) begin
      Ds = 2'($urandom);
      tick();
    end
    n_checks++;
    if (Q_m !== qm_prev || Q_l !== ql_prev || Carry_m !== cm_prev || Busy_m !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_shift_ignored: q %h/%h expected %h/%h", Q_m, Q_l, qm_prev, ql_prev);
    end
    ShiftEn = 1'b0;
  endtask

  task automatic test_hold_full();
    logic [CH*W-1:0] word_b;
    do_reset();
    LoadValid = 1'b1; Dp = 16'($urandom); ShiftEn = 1'b0;
    tick();                       // accept A
    tick();                       // A to lanes
    word_b = 16'($urandom);
    Dp = word_b;
    tick();                       // accept B
    for (int c = 0; c < 4; c++) begin
      Dp = 16'($urandom);
      n_checks++;
      if (LoadReady_m !== 1'b0 || LoadReady_l !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_full_ready[%0d]: got %b/%b expected 0", c, LoadReady_m, LoadReady_l);
      end
      tick();
    end
    ShiftEn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      Dp = 16'($urandom);
      Ds = 2'($urandom);
      tick();
    end
    LoadValid = 1'b0;
    n_checks++;
    if (Q_m !== word_b || Q_l !== word_b || {Busy_m, Done_m, Underrun_m} !== 3'b110) begin
      n_fail++;
      $display("FAIL hold_full_reload: q %h/%h flags %b expected %h 110",
               Q_m, Q_l, {Busy_m, Done_m, Underrun_m}, word_b);
    end
    ShiftEn = 1'b0;
  endtask

  task automatic test_preset_midshift();
    do_reset();
    LoadValid = 1'b1; Dp = 16'($urandom) | 16'h0101; ShiftEn = 1'b1; Ds = 2'b11;
    tick();
    Dp = 16'($urandom);
    tick();
    tick();                       // second word accepted, first is shifting
    LoadValid = 1'b0;
    tick();
    #2;
    Preset = 1'b1;
    #1;
    n_checks++;
    if ({Q_m, Q_l, Carry_m, Carry_l, Busy_m, Done_m, Underrun_m, LoadReady_m, LoadReady_l} !==
        {32'h0, 4'h0, 3'b000, 2'b11}) begin
      n_fail++;
      $display("FAIL preset_async: q %h/%h carry %b busy %b ready %b expected all 0, ready 1",
               Q_m, Q_l, Carry_m, Busy_m, LoadReady_m);
    end
    @(negedge Clock);
    Preset = 1'b0;
    ShiftEn = 1'b1;
    tick();
    n_checks++;
    if (Busy_m !== 1'b0 || Q_m !== 16'h0000 || LoadReady_m !== 1'b1) begin
      n_fail++;
      $display("FAIL preset_discards_words: busy %b q %h ready %b expected 0 0000 1",
               Busy_m, Q_m, LoadReady_m);
    end
    ShiftEn = 1'b0;
  endtask

  task automatic test_random();
    logic [21:0] exp_o, got_o;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      LoadValid = 1'($urandom_range(0, 1));
      Dp        = 16'($urandom);
      Ds        = 2'($urandom);
      ShiftEn   = ($urandom_range(0, 3) != 0);
      tick();
      exp_o = {mm.act, mm.carry, mm.busy, mm.done, mm.under, !mm.hold_full};
      got_o = {Q_m, Carry_m, Busy_m, Done_m, Underrun_m, LoadReady_m};
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL random_msb[%0d]: got %h expected %h", c, got_o, exp_o);
      end
      exp_o = {ml.act, ml.carry, ml.busy, ml.done, ml.under, !ml.hold_full};
      got_o = {Q_l, Carry_l, Busy_l, Done_l, Underrun_l, LoadReady_l};
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL random_lsb[%0d]: got %h expected %h", c, got_o, exp_o);
      end
    end
    LoadValid = 1'b0;
    ShiftEn   = 1'b0;
  endtask

  initial begin
    Preset = 1'b1; LoadValid = 1'b0; ShiftEn = 1'b0; Ds = '0; Dp = '0;
    test_reset();
    test_carry_order();
    test_back_to_back();
    test_toggle();
    test_hold_full();
    test_preset_midshift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_engine
